// File: rtl/shift_sequencer_if.sv
// Request/response bundle between the execute-stage control and the shift sequencer.
interface shift_sequencer_if;
  logic        start;
  logic [1:0]  op;
  logic [15:0] in;
  logic [3:0]  amt;
  logic        busy;
  logic        done;
  logic [15:0] out;

  modport master (output start, op, in, amt, input  busy, done, out);
  modport slave  (input  start, op, in, amt, output busy, done, out);
endinterface

// File: rtl/shift_sequencer.sv
// 16-bit shift/rotate sequencer: one logarithmic stage (1,2,4,8) per clock,
// exits early once no higher amount bits remain, then pulses done for one cycle.
module shift_sequencer (
  input  logic               clk,
  input  logic               rst_n,
  shift_sequencer_if.slave   bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  state_t      state;
  logic [15:0] acc, nxt_acc, out_r;
  logic [3:0]  amt_r;
  logic [1:0]  op_r, stage;
  logic [4:0]  sh;
  logic        last, busy_r, done_r;

  always_comb begin
    sh      = 5'd1 << stage;
    nxt_acc = acc;
    if (amt_r[stage]) begin
      case (op_r)
        OP_SLL:  nxt_acc = acc << sh;
        OP_SRL:  nxt_acc = acc >> sh;
        OP_SRA:  nxt_acc = $signed(acc) >>> sh;
        OP_ROR:  nxt_acc = (acc >> sh) | (acc << (5'd16 - sh));
        default: nxt_acc = acc;
      endcase
    end
    // Done once every amount bit above the current stage is zero.
    case (stage)
      2'd0:    last = (amt_r[3:1] == 3'b000);
      2'd1:    last = (amt_r[3:2] == 2'b00);
      2'd2:    last = ~amt_r[3];
      default: last = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      acc    <= '0;
      amt_r  <= '0;
      op_r   <= '0;
      stage  <= '0;
      out_r  <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            acc    <= bus.in;
            amt_r  <= bus.amt;
            op_r   <= bus.op;
            stage  <= 2'd0;
            busy_r <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          acc <= nxt_acc;
          if (last) begin
            out_r  <= nxt_acc;
            done_r <= 1'b1;
            state  <= DONE;
          end else begin
            stage <= stage + 2'd1;
          end
        end
        DONE: begin
          done_r <= 1'b0;
          busy_r <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          done_r <= 1'b0;
          busy_r <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.out  = out_r;
endmodule

// File: tb/tb_shift_sequencer.sv
// Directed table plus corner sequences and a random sweep for shift_sequencer.
module tb_shift_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  shift_sequencer_if sif ();

  shift_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(sif.slave));

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [1:0]  op;
    logic [15:0] din;
    logic [3:0]  amt;
    logic [15:0] exp_out;
    int          exp_n;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] ref_fn(input logic [1:0] op, input logic [15:0] d, input logic [3:0] a);
    logic [31:0] dd;
    dd = {d, d} >> a;
    case (op)
      2'b00:   return d << a;
      2'b01:   return d >> a;
      2'b10:   return $signed(d) >>> a;
      default: return dd[15:0];
    endcase
  endfunction

  function automatic int ref_n(input logic [3:0] a);
    int n;
    n = 1;
    for (int i = 0; i < 4; i++) if (a[i]) n = i + 1;
    return n;
  endfunction

  // Captures at the next posedge, then counts edges until done is seen.
  task automatic run_op(input string name, input logic [1:0] op, input logic [15:0] d,
                        input logic [3:0] a, input logic [15:0] exp_out, input int exp_n);
    int cnt;
    logic busy_ok;
    sif.op = op; sif.in = d; sif.amt = a; sif.start = 1'b1;
    @(posedge clk); #1;
    sif.start = 1'b0;
    sif.in = ~d; sif.amt = ~a; sif.op = ~op;
    cnt = 0;
    busy_ok = 1'b1;
    while (cnt < 10) begin
      if (!sif.busy) busy_ok = 1'b0;
      @(posedge clk); #1;
      cnt++;
      if (sif.done) break;
    end
    chk({name, "_lat"}, cnt, exp_n);
    chk({name, "_out"}, sif.out, exp_out);
    chk({name, "_busy"}, {busy_ok, sif.busy}, 2'b11);
    @(posedge clk); #1;
    chk({name, "_end"}, {sif.busy, sif.done}, 2'b00);
  endtask

  task automatic wait_done(output int cnt);
    cnt = 0;
    while (cnt < 10) begin
      @(posedge clk); #1;
      cnt++;
      if (sif.done) break;
    end
  endtask

  initial begin
    int cnt, dones;
    logic [1:0] rop;
    logic [15:0] rin;
    logic [3:0] ramt;

    vecs[0]  = '{2'b11, 16'h8001, 4'd1,  16'hC000, 1};
    vecs[1]  = '{2'b10, 16'h8000, 4'd15, 16'hFFFF, 4};
    vecs[2]  = '{2'b01, 16'h8000, 4'd15, 16'h0001, 4};
    vecs[3]  = '{2'b00, 16'h0001, 4'd8,  16'h0100, 4};
    vecs[4]  = '{2'b01, 16'hF0F0, 4'd0,  16'hF0F0, 1};
    vecs[5]  = '{2'b00, 16'h1234, 4'd4,  16'h2340, 3};
    vecs[6]  = '{2'b10, 16'h7F00, 4'd3,  16'h0FE0, 2};
    vecs[7]  = '{2'b10, 16'hF000, 4'd2,  16'hFC00, 2};
    vecs[8]  = '{2'b11, 16'h1234, 4'd4,  16'h4123, 3};
    vecs[9]  = '{2'b11, 16'h00FF, 4'd15, 16'h01FE, 4};
    vecs[10] = '{2'b00, 16'h8001, 4'd1,  16'h0002, 1};
    vecs[11] = '{2'b01, 16'hFFFF, 4'd5,  16'h07FF, 3};

    sif.start = 1'b0; sif.op = '0; sif.in = '0; sif.amt = '0;
    #12;
    chk("reset_state", {sif.busy, sif.done, sif.out}, 18'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].din, vecs[i].amt, vecs[i].exp_out, vecs[i].exp_n);

    // start held high: only IDLE-sampled operands matter, one done per op.
    sif.op = 2'b00; sif.in = 16'h00F0; sif.amt = 4'd4; sif.start = 1'b1;
    @(posedge clk); #1;
    sif.op = 2'b11; sif.in = 16'hAAAA; sif.amt = 4'd9;
    wait_done(cnt);
    chk("held_a_lat", cnt, 3);
    chk("held_a_out", sif.out, 16'h0F00);
    sif.op = 2'b10; sif.in = 16'h8421; sif.amt = 4'd1;
    wait_done(cnt);
    chk("held_b_lat", cnt, 3);
    chk("held_b_out", sif.out, 16'hC210);
    sif.start = 1'b0;
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (sif.done) dones++;
    end
    chk("held_no_extra_done", dones, 0);
    chk("held_idle", sif.busy, 1'b0);

    // Reset mid-RUN discards the operation.
    sif.op = 2'b00; sif.in = 16'hFFFF; sif.amt = 4'd12; sif.start = 1'b1;
    @(posedge clk); #1;
    sif.start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_run", {sif.busy, sif.done, sif.out}, 18'h0);
    dones = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (sif.done || sif.busy) dones++;
    end
    chk("rst_no_done", dones, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_rst", 2'b11, 16'h1234, 4'd4, 16'h4123, 3);

    // Random sweep against the single-cycle reference.
    for (int i = 0; i < 2000; i++) begin
      rop  = 2'($urandom_range(0, 3));
      rin  = 16'($urandom);
      ramt = 4'($urandom_range(0, 15));
      run_op($sformatf("rnd%0d", i), rop, rin, ramt, ref_fn(rop, rin, ramt), ref_n(ramt));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
